jedro_1_data_ram: RTL and testbench

- Responder (slave) end of the core's load/store RAM read/write port: the memory the jedro_1 core's data master talks to.
- Accepts one request per cycle, performs byte-enabled writes or word reads, and returns a response after a fixed, parameterised latency.
- Reports out-of-range and misaligned accesses as error responses.
- Includes a post-reset zero-fill state machine so simulation and FPGA images start from a known memory state.

---
 rtl/jedro_1_data_ram_pkg.sv | 19 +
 rtl/jedro_1_data_ram_if.sv | 27 ++
 rtl/jedro_1_data_ram_resp_pipe.sv | 47 ++++
 rtl/jedro_1_data_ram.sv | 125 ++++++++++++
 tb/tb_jedro_1_data_ram.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/jedro_1_data_ram_pkg.sv
// Shared types for the jedro_1 data RAM responder: byte-enable width,
// response record and the init/run state encoding.
package jedro_1_defines;

    localparam int unsigned RAM_BE_WIDTH   = 4;
    localparam int unsigned RAM_DATA_WIDTH = 32;

    typedef struct packed {
        logic                      valid;
        logic                      err;
        logic [RAM_DATA_WIDTH-1:0] data;
    } ram_resp_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ram_state_t;

endpackage

// File: rtl/jedro_1_data_ram_if.sv
// Load/store port between the jedro_1 data master and the data RAM.
interface jedro_1_data_ram_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    import jedro_1_defines::*;

    logic                    en_i;
    logic [RAM_BE_WIDTH-1:0] we_i;
    logic [ADDR_WIDTH-1:0]   addr_i;
    logic [DATA_WIDTH-1:0]   wdata_i;
    logic                    ready_o;
    logic                    rvalid_o;
    logic [DATA_WIDTH-1:0]   rdata_o;
    logic                    err_o;

    modport master (
        output en_i, we_i, addr_i, wdata_i,
        input  ready_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  en_i, we_i, addr_i, wdata_i,
        output ready_o, rvalid_o, rdata_o, err_o
    );

endinterface

// File: rtl/jedro_1_data_ram_resp_pipe.sv
// Delay line for RAM responses; data fields only advance with a valid
// response so the output keeps the last returned word between responses.
module jedro_1_ram_resp_pipe
    import jedro_1_defines::*;
#(
    parameter int unsigned STAGES = 0
) (
    input  logic      clk_i,
    input  logic      rstn_i,
    input  ram_resp_t resp_i,
    output ram_resp_t resp_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk_i ^ rstn_i;
            assign resp_o         = resp_i;
        end else begin : g_pipe
            ram_resp_t stage_q [STAGES];

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    for (int i = 0; i < int'(STAGES); i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0].valid <= resp_i.valid;
                    stage_q[0].err   <= resp_i.err;
                    if (resp_i.valid) begin
                        stage_q[0].data <= resp_i.data;
                    end
                    for (int i = 1; i < int'(STAGES); i++) begin
                        stage_q[i].valid <= stage_q[i-1].valid;
                        stage_q[i].err   <= stage_q[i-1].err;
                        if (stage_q[i-1].valid) begin
                            stage_q[i].data <= stage_q[i-1].data;
                        end
                    end
                end
            end

            assign resp_o = stage_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/jedro_1_data_ram.sv
// Data RAM responder for the jedro_1 load/store port: byte-enabled writes,
// word reads, error responses for bad addresses, fixed response latency.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   INIT  | zero-filling one word per cycle, requests not accepted
//   RUN   | accepting one request per cycle
module jedro_1_data_ram
    import jedro_1_defines::*;
#(
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           MEM_SIZE_WORDS = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter int unsigned           READ_LATENCY   = 1,
    parameter bit                    INIT_ZERO      = 1'b1
) (
    input logic               clk_i,
    input logic               rstn_i,
    jedro_1_data_ram_if.slave bus
);

    localparam int unsigned           IDX_W       = $clog2(MEM_SIZE_WORDS);
    localparam logic [ADDR_WIDTH:0]   MEM_BYTES   = (ADDR_WIDTH+1)'(MEM_SIZE_WORDS * 4);
    localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(MEM_SIZE_WORDS - 1);
    localparam ram_state_t            RESET_STATE = INIT_ZERO ? INIT : RUN;

    logic [DATA_WIDTH-1:0] mem [MEM_SIZE_WORDS];

    ram_state_t            state_q, state_d;
    logic [IDX_W-1:0]      init_cnt_q, init_cnt_d;
    logic                  init_we;
    logic                  ready_q;

    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      idx;
    logic                  range_err, align_err, is_err;
    logic                  accept, do_write, do_read;

    ram_resp_t             resp_q, resp_pipe;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= RESET_STATE;
            init_cnt_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ready_q    <= (state_d == RUN);
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        init_we    = 1'b0;
        unique case (state_q)
            INIT: begin
                init_we    = 1'b1;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == LAST_IDX) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Range check is done on the subtracted offset so no address aliases to word 0.
    assign offset    = bus.addr_i - BASE_ADDR;
    assign idx       = offset[IDX_W+1:2];
    assign range_err = (bus.addr_i < BASE_ADDR) || ({1'b0, offset} >= MEM_BYTES);
    assign align_err = (bus.addr_i[1:0] != 2'b00);
    assign is_err    = range_err | align_err;

    assign accept    = bus.en_i & ready_q;
    assign do_write  = accept & ~is_err & (bus.we_i != '0);
    assign do_read   = accept & ~is_err & (bus.we_i == '0);

    always_ff @(posedge clk_i) begin
        if (init_we) begin
            mem[init_cnt_q] <= '0;
        end else if (do_write) begin
            for (int k = 0; k < int'(RAM_BE_WIDTH); k++) begin
                if (bus.we_i[k]) begin
                    mem[idx][8*k +: 8] <= bus.wdata_i[8*k +: 8];
                end
            end
        end
    end

    // First response stage: the registered array read.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            resp_q <= '0;
        end else begin
            resp_q.valid <= accept;
            resp_q.err   <= accept & is_err;
            if (accept) begin
                resp_q.data <= do_read ? mem[idx] : '0;
            end
        end
    end

    jedro_1_ram_resp_pipe #(
        .STAGES (READ_LATENCY - 1)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .resp_i (resp_q),
        .resp_o (resp_pipe)
    );

    assign bus.ready_o  = ready_q;
    assign bus.rvalid_o = resp_pipe.valid;
    assign bus.err_o    = resp_pipe.err;
    assign bus.rdata_o  = resp_pipe.data;

endmodule

// File: tb/tb_jedro_1_data_ram.sv
// Bench for jedro_1_data_ram: two instances (latency 1 and 3) driven with the
// same directed and random requests, checked against a word-array model.
module tb_jedro_1_data_ram;
    import jedro_1_defines::*;

    localparam int          MEM  = 16;
    localparam logic [31:0] BASE = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    jedro_1_data_ram_if bus1 ();
    jedro_1_data_ram_if bus3 ();

    jedro_1_data_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE_WORDS(MEM),
        .BASE_ADDR(BASE), .READ_LATENCY(1), .INIT_ZERO(1'b1)
    ) dut1 (.clk_i(clk), .rstn_i(rst_n), .bus(bus1));

    jedro_1_data_ram #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_SIZE_WORDS(MEM),
        .BASE_ADDR(BASE), .READ_LATENCY(3), .INIT_ZERO(1'b1)
    ) dut3 (.clk_i(clk), .rstn_i(rst_n), .bus(bus3));

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] model_mem [MEM];
    int          init_left;
    int          cyc;
    logic [31:0] last1, last3;
    int          errors;
    int          checks;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_resp(input string tag, input logic rv, input logic er,
                              input logic [31:0] rd, input bit due_now, input exp_t e,
                              inout logic [31:0] last);
        if (due_now) begin
            check_val({tag, "_rvalid"}, {31'b0, rv}, 32'd1);
            check_val({tag, "_err"},    {31'b0, er}, {31'b0, e.err});
            check_val({tag, "_rdata"},  rd, e.data);
            last = e.data;
        end else begin
            check_val({tag, "_rvalid_idle"}, {31'b0, rv}, 32'd0);
            check_val({tag, "_err_idle"},    {31'b0, er}, 32'd0);
            check_val({tag, "_rdata_hold"},  rd, last);
        end
    endtask

    task automatic sample();
        exp_t e;
        bit   d;
        check_val("ready1", {31'b0, bus1.ready_o}, {31'b0, init_left == 0});
        check_val("ready3", {31'b0, bus3.ready_o}, {31'b0, init_left == 0});
        e = '{0, 1'b0, 32'h0};
        d = (q1.size() > 0) && (q1[0].due == cyc);
        if (d) e = q1.pop_front();
        check_resp("lat1", bus1.rvalid_o, bus1.err_o, bus1.rdata_o, d, e, last1);
        e = '{0, 1'b0, 32'h0};
        d = (q3.size() > 0) && (q3[0].due == cyc);
        if (d) e = q3.pop_front();
        check_resp("lat3", bus3.rvalid_o, bus3.err_o, bus3.rdata_o, d, e, last3);
    endtask

    task automatic model_accept(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] off;
        logic [31:0] data;
        bit          er;
        int          idx;
        off  = addr - BASE;
        er   = (addr < BASE) || (off >= MEM * 4) || (addr[1:0] != 2'b00);
        data = 32'h0;
        if (!er) begin
            idx = int'(off / 4);
            if (we != 4'h0) begin
                for (int k = 0; k < 4; k++)
                    if (we[k]) model_mem[idx][8*k +: 8] = wd[8*k +: 8];
            end else begin
                data = model_mem[idx];
            end
        end
        q1.push_back('{cyc,     er, data});
        q3.push_back('{cyc + 2, er, data});
    endtask

    task automatic drive(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        bus1.en_i = en; bus1.we_i = we; bus1.addr_i = addr; bus1.wdata_i = wd;
        bus3.en_i = en; bus3.we_i = we; bus3.addr_i = addr; bus3.wdata_i = wd;
    endtask

    task automatic step(input logic en, input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wd);
        drive(en, we, addr, wd);
        @(posedge clk);
        cyc++;
        if (init_left > 0) init_left--;
        else if (en) model_accept(we, addr, wd);
        @(negedge clk);
        sample();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        #1;
        check_val("rst_ready1",  {31'b0, bus1.ready_o},  32'd0);
        check_val("rst_rvalid1", {31'b0, bus1.rvalid_o}, 32'd0);
        check_val("rst_err1",    {31'b0, bus1.err_o},    32'd0);
        check_val("rst_rdata1",  bus1.rdata_o,           32'd0);
        check_val("rst_ready3",  {31'b0, bus3.ready_o},  32'd0);
        check_val("rst_rvalid3", {31'b0, bus3.rvalid_o}, 32'd0);
        check_val("rst_err3",    {31'b0, bus3.err_o},    32'd0);
        check_val("rst_rdata3",  bus3.rdata_o,           32'd0);
        q1.delete();
        q3.delete();
        last1 = 32'h0;
        last3 = 32'h0;
        init_left = MEM;
        for (int i = 0; i < MEM; i++) model_mem[i] = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0]  r_we;
        logic [31:0] r_addr;
        errors = 0;
        checks = 0;
        cyc    = 0;
        drive(1'b0, 4'h0, 32'h0, 32'h0);
        #2;
        do_reset();

        // Requests held during the zero fill must be ignored.
        repeat (MEM) step(1'b1, 4'h0, 32'h0, 32'h0);

        step(1'b1, 4'h0, 32'h0000_0000, 32'h0);
        step(1'b1, 4'h0, 32'h0000_003C, 32'h0);
        step(1'b1, 4'hF, 32'h0000_0008, 32'hDEAD_BEEF);
        step(1'b1, 4'h0, 32'h0000_0008, 32'h0);
        step(1'b1, 4'h2, 32'h0000_0008, 32'h0000_1100);
        step(1'b1, 4'h0, 32'h0000_0008, 32'h0);
        step(1'b1, 4'h0, 32'h0000_0040, 32'h0);
        step(1'b1, 4'h0, 32'h0000_0006, 32'h0);
        step(1'b1, 4'hF, 32'h0000_0009, 32'hFFFF_FFFF);
        step(1'b1, 4'h0, 32'h0000_0008, 32'h0);
        step(1'b0, 4'h0, 32'h0, 32'h0);
        step(1'b1, 4'h0, 32'h0000_0000, 32'h0);
        step(1'b1, 4'h0, 32'h0000_0004, 32'h0);
        step(1'b1, 4'h0, 32'h0000_0008, 32'h0);
        repeat (4) step(1'b0, 4'h0, 32'h0, 32'h0);

        for (int n = 0; n < 400; n++) begin
            r_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            case ($urandom_range(0, 3))
                0, 3:    r_addr = {26'h0, 4'($urandom_range(0, MEM - 1)), 2'b00};
                1:       r_addr = 32'($urandom_range(0, 32'h4F));
                default: r_addr = $urandom();
            endcase
            step($urandom_range(0, 3) != 0, r_we, r_addr, $urandom());
        end

        // Two reads in flight when reset hits must never respond.
        step(1'b1, 4'hF, 32'h0000_0008, 32'h1234_5678);
        step(1'b1, 4'h0, 32'h0000_0008, 32'h0);
        step(1'b1, 4'h0, 32'h0000_0000, 32'h0);
        do_reset();
        repeat (MEM) step(1'b1, 4'h0, 32'h0000_0008, 32'h0);
        step(1'b1, 4'h0, 32'h0000_0008, 32'h0);
        step(1'b1, 4'h0, 32'h0000_003C, 32'h0);
        repeat (4) step(1'b0, 4'h0, 32'h0, 32'h0);

        check_val("drain_lat1", 32'(q1.size()), 32'd0);
        check_val("drain_lat3", 32'(q3.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
